// File: rtl/loop_player_if.sv
// ============================================================================
// Module      : loop_player_if
// Description : Synchronous BRAM read port used by the loop player.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface loop_player_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic        [ADDR_WIDTH-1:0] mem_addr_out;
    logic signed [DATA_WIDTH-1:0] mem_data_in;

    modport master (output mem_addr_out, input mem_data_in);
    modport slave  (input mem_addr_out, output mem_data_in);
endinterface

`default_nettype wire

// File: rtl/loop_player.sv
// ============================================================================
// Module      : loop_player
// Description : Looper playback engine; prefetches samples from BRAM and
//               emits one signed sample per audio tick (one-shot or looped).
//               Optional macro LOOP_PLAYER_REVERSE_EN adds reverse playback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module loop_player #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 2
) (
    input  wire logic                         clk_in,
    input  wire logic                         rst_in,
    input  wire logic                         start_in,
    input  wire logic                         stop_in,
    input  wire logic                         loop_in,
    input  wire logic        [ADDR_WIDTH-1:0] rec_len_in,
    input  wire logic                         sample_tick_in,
`ifdef LOOP_PLAYER_REVERSE_EN
    input  wire logic                         reverse_in,
`endif
    output logic signed      [DATA_WIDTH-1:0] sample_out,
    output logic                              sample_valid_out,
    output logic                              busy_out,
    output logic                              done_out,
    output logic                              underrun_out,
    loop_player_if.master                     mem
);

    localparam int c_CW = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);
    localparam logic [c_CW-1:0]       c_LAT      = c_CW'(READ_LATENCY);
    localparam logic [c_CW-1:0]       c_CNT_ONE  = c_CW'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t                       r_state_q,  w_state_d;
    logic        [ADDR_WIDTH-1:0] r_addr_q,   w_addr_d;
    logic        [ADDR_WIDTH-1:0] r_len_q,    w_len_d;
    logic        [c_CW-1:0]       r_cnt_q,    w_cnt_d;
    logic signed [DATA_WIDTH-1:0] r_pref_q,   w_pref_d;
    logic signed [DATA_WIDTH-1:0] r_sample_q, w_sample_d;
    logic                         r_valid_q,  w_valid_d;
    logic                         r_done_q,   w_done_d;
    logic                         r_under_q,  w_under_d;
    logic                         r_rev_q,    w_rev_d;

    logic w_rev_sel;
    logic w_start_ok;
    logic w_last;
    logic [ADDR_WIDTH-1:0] w_wrap_addr;
    logic [ADDR_WIDTH-1:0] w_step_addr;

`ifdef LOOP_PLAYER_REVERSE_EN
    assign w_rev_sel = reverse_in;
`else
    assign w_rev_sel = 1'b0;
`endif

    // A zero-length start is treated as if no start had been issued.
    assign w_start_ok  = start_in && (rec_len_in != '0);
    assign w_last      = r_rev_q ? (r_addr_q == '0) : (r_addr_q == r_len_q - c_ADDR_ONE);
    assign w_wrap_addr = r_rev_q ? (r_len_q - c_ADDR_ONE) : '0;
    assign w_step_addr = r_rev_q ? (r_addr_q - c_ADDR_ONE) : (r_addr_q + c_ADDR_ONE);

    always_comb begin
        w_state_d  = r_state_q;
        w_addr_d   = r_addr_q;
        w_len_d    = r_len_q;
        w_cnt_d    = r_cnt_q;
        w_pref_d   = r_pref_q;
        w_sample_d = r_sample_q;
        w_valid_d  = 1'b0;
        w_done_d   = 1'b0;
        w_under_d  = r_under_q;
        w_rev_d    = r_rev_q;

        if (stop_in) begin
            w_state_d  = S_IDLE;
            w_sample_d = '0;
        end else if (w_start_ok) begin
            w_state_d  = S_FETCH;
            w_len_d    = rec_len_in;
            w_rev_d    = w_rev_sel;
            w_addr_d   = w_rev_sel ? (rec_len_in - c_ADDR_ONE) : '0;
            w_cnt_d    = '0;
            w_under_d  = 1'b0;
            w_sample_d = '0;
        end else begin
            case (r_state_q)
                S_IDLE: begin
                end
                S_FETCH: begin
                    // Tick arrived too early: emit silence, keep fetching.
                    if (sample_tick_in) begin
                        w_under_d  = 1'b1;
                        w_valid_d  = 1'b1;
                        w_sample_d = '0;
                    end
                    if (r_cnt_q == c_LAT) begin
                        w_pref_d  = mem.mem_data_in;
                        w_state_d = S_READY;
                    end else begin
                        w_cnt_d = r_cnt_q + c_CNT_ONE;
                    end
                end
                S_READY: begin
                    if (sample_tick_in) begin
                        w_sample_d = r_pref_q;
                        w_valid_d  = 1'b1;
                        w_cnt_d    = '0;
                        if (!w_last) begin
                            w_addr_d  = w_step_addr;
                            w_state_d = S_FETCH;
                        end else if (loop_in) begin
                            w_addr_d  = w_wrap_addr;
                            w_state_d = S_FETCH;
                        end else begin
                            w_state_d = S_IDLE;
                            w_done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state_q  <= S_IDLE;
            r_addr_q   <= '0;
            r_len_q    <= '0;
            r_cnt_q    <= '0;
            r_pref_q   <= '0;
            r_sample_q <= '0;
            r_valid_q  <= 1'b0;
            r_done_q   <= 1'b0;
            r_under_q  <= 1'b0;
            r_rev_q    <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_addr_q   <= w_addr_d;
            r_len_q    <= w_len_d;
            r_cnt_q    <= w_cnt_d;
            r_pref_q   <= w_pref_d;
            r_sample_q <= w_sample_d;
            r_valid_q  <= w_valid_d;
            r_done_q   <= w_done_d;
            r_under_q  <= w_under_d;
            r_rev_q    <= w_rev_d;
        end
    end

    assign mem.mem_addr_out = r_addr_q;
    assign sample_out       = r_sample_q;
    assign sample_valid_out = r_valid_q;
    assign busy_out         = (r_state_q != S_IDLE);
    assign done_out         = r_done_q;
    assign underrun_out     = r_under_q;

endmodule

`default_nettype wire

// File: tb/tb_loop_player.sv
// ============================================================================
// Module      : tb_loop_player
// Description : Self-checking bench for loop_player (vector table, directed
//               corner cases, random stimulus against a timing-rule model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_loop_player;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int RL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          stop  = 1'b0;
    logic          tick  = 1'b0;
    logic          loop_l = 1'b0;
    logic [AW-1:0] len   = '0;
`ifdef LOOP_PLAYER_REVERSE_EN
    logic          reverse = 1'b0;
`endif

    logic signed [DW-1:0] sample;
    logic valid, busy, done, under;

    loop_player_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    loop_player #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .start_in        (start),
        .stop_in         (stop),
        .loop_in         (loop_l),
        .rec_len_in      (len),
        .sample_tick_in  (tick),
`ifdef LOOP_PLAYER_REVERSE_EN
        .reverse_in      (reverse),
`endif
        .sample_out      (sample),
        .sample_valid_out(valid),
        .busy_out        (busy),
        .done_out        (done),
        .underrun_out    (under),
        .mem             (bus)
    );

    // Two-stage registered BRAM read model
    logic [7:0] mem [0:255];
    logic [7:0] p1, p2;
    always @(posedge clk) begin
        p1 <= mem[bus.mem_addr_out[7:0]];
        p2 <= p1;
    end
    assign bus.mem_data_in = p2;

    int total = 0;
    int bad   = 0;

    // Reference model: a sample is ready once RL+2 cycles have elapsed since
    // its fetch began; earlier ticks are underruns.
    int         n = 0;
    int         m_fstart, m_pos, m_len;
    bit         m_busy, m_valid, m_done, m_under, m_rev;
    logic [7:0] m_sample = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, n);
        end
    endtask

    task automatic model_update();
        bit last;
        m_valid = 1'b0;
        m_done  = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_sample = 8'h00; m_under = 1'b0; m_pos = 0; m_len = 0; m_rev = 1'b0;
        end else if (stop) begin
            m_busy = 1'b0; m_sample = 8'h00;
        end else if (start && len != 0) begin
`ifdef LOOP_PLAYER_REVERSE_EN
            m_rev = reverse;
`else
            m_rev = 1'b0;
`endif
            m_busy = 1'b1; m_len = int'(len);
            m_pos = m_rev ? m_len - 1 : 0;
            m_fstart = n; m_under = 1'b0; m_sample = 8'h00;
        end else if (m_busy && tick) begin
            m_valid = 1'b1;
            if (n - m_fstart < RL + 2) begin
                m_under = 1'b1; m_sample = 8'h00;
            end else begin
                m_sample = mem[m_pos];
                last = m_rev ? (m_pos == 0) : (m_pos == m_len - 1);
                if (!last) begin
                    m_pos = m_rev ? m_pos - 1 : m_pos + 1;
                    m_fstart = n;
                end else if (loop_l) begin
                    m_pos = m_rev ? m_len - 1 : 0;
                    m_fstart = n;
                end else begin
                    m_busy = 1'b0; m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic model_check();
        chk("busy",     busy,  m_busy);
        chk("valid",    valid, m_valid);
        chk("done",     done,  m_done);
        chk("underrun", under, m_under);
        chk("sample",   {24'h0, sample}, {24'h0, m_sample});
        if (m_busy) chk("addr", bus.mem_addr_out, m_pos[15:0]);
    endtask

    task automatic step(input logic s, input logic p, input logic t, input logic r);
        start = s; stop = p; tick = t; rst = r;
        @(posedge clk);
        n++;
        model_update();
        #1;
        model_check();
        start = 1'b0; stop = 1'b0; tick = 1'b0; rst = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct packed {
        logic [15:0] len;
        logic        loop;
        logic        rev;
        logic [7:0]  nticks;
        logic [7:0]  gap;
        logic [79:0] exp;      // sample k at exp[k*8 +: 8]
        logic        exp_done;
    } vec_t;

`ifdef LOOP_PLAYER_REVERSE_EN
    localparam int N_VEC = 6;
`else
    localparam int N_VEC = 5;
`endif
    vec_t vecs [N_VEC];

    initial begin
        vec_t v;

        vecs[0] = '{16'd4, 1'b0, 1'b0, 8'd4,  8'd10, {48'h0, 8'h80, 8'h07, 8'hFD, 8'h05}, 1'b1};
        vecs[1] = '{16'd4, 1'b1, 1'b0, 8'd10, 8'd10,
                    {8'hFD, 8'h05, 8'h80, 8'h07, 8'hFD, 8'h05, 8'h80, 8'h07, 8'hFD, 8'h05}, 1'b0};
        vecs[2] = '{16'd1, 1'b1, 1'b0, 8'd3,  8'd10, {56'h0, 8'h05, 8'h05, 8'h05}, 1'b0};
        vecs[3] = '{16'd3, 1'b0, 1'b0, 8'd3,  8'd4,  {56'h0, 8'h07, 8'hFD, 8'h05}, 1'b1};
        vecs[4] = '{16'd2, 1'b1, 1'b0, 8'd5,  8'd4,  {40'h0, 8'h05, 8'hFD, 8'h05, 8'hFD, 8'h05}, 1'b0};
`ifdef LOOP_PLAYER_REVERSE_EN
        vecs[5] = '{16'd4, 1'b0, 1'b1, 8'd4,  8'd10, {48'h0, 8'h05, 8'hFD, 8'h07, 8'h80}, 1'b1};
`endif

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h05; mem[1] = 8'hFD; mem[2] = 8'h07; mem[3] = 8'h80;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_addr",   bus.mem_addr_out, 32'h0);
        chk("rst_sample", {24'h0, sample}, 32'h0);
        chk("rst_busy",   busy, 32'h0);

        // Vector table
        for (int i = 0; i < N_VEC; i++) begin
            v = vecs[i];
            step(1'b0, 1'b0, 1'b0, 1'b1);
            len = v.len;
            loop_l = v.loop;
`ifdef LOOP_PLAYER_REVERSE_EN
            reverse = v.rev;
`endif
            step(1'b1, 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < int'(v.nticks); k++) begin
                idle(int'(v.gap) - 1);
                step(1'b0, 1'b0, 1'b1, 1'b0);
                chk("vec_valid",  valid, 32'h1);
                chk("vec_sample", {24'h0, sample}, {24'h0, v.exp[k*8 +: 8]});
                chk("vec_done",   done, {31'h0, (k == int'(v.nticks) - 1) && v.exp_done});
            end
            if (v.exp_done) begin
                idle(2);
                chk("vec_idle_busy", busy, 32'h0);
                chk("vec_hold", {24'h0, sample}, {24'h0, v.exp[(int'(v.nticks) - 1)*8 +: 8]});
            end else begin
                step(1'b0, 1'b1, 1'b0, 1'b0);
                chk("vec_stop_busy",   busy, 32'h0);
                chk("vec_stop_sample", {24'h0, sample}, 32'h0);
            end
        end
`ifdef LOOP_PLAYER_REVERSE_EN
        reverse = 1'b0;
`endif

        // Underrun: tick one cycle after start
        step(1'b0, 1'b0, 1'b0, 1'b1);
        len = 16'd4; loop_l = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("ur_flag",   under, 32'h1);
        chk("ur_valid",  valid, 32'h1);
        chk("ur_sample", {24'h0, sample}, 32'h0);
        idle(4);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("ur_next",   {24'h0, sample}, 32'h05);
        chk("ur_sticky", under, 32'h1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ur_clear",  under, 32'h0);

        // Zero-length start is ignored
        step(1'b0, 1'b0, 1'b0, 1'b1);
        len = 16'd0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        chk("len0_busy", busy, 32'h0);
        chk("len0_addr", bus.mem_addr_out, 32'h0);

        // Start and stop together at addr 2
        step(1'b0, 1'b0, 1'b0, 1'b1);
        len = 16'd4; loop_l = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            idle(4);
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        idle(1);
        chk("mid_addr", bus.mem_addr_out, 32'h2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("ss_busy",   busy, 32'h0);
        chk("ss_done",   done, 32'h0);
        chk("ss_sample", {24'h0, sample}, 32'h0);

        // Reset during FETCH with underrun set and addr nonzero
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_under", under, 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rf_busy",   busy,  32'h0);
        chk("rf_valid",  valid, 32'h0);
        chk("rf_under",  under, 32'h0);
        chk("rf_sample", {24'h0, sample}, 32'h0);
        chk("rf_addr",   bus.mem_addr_out, 32'h0);

        // Randomized stimulus against the model
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 3000; i++) begin
            len    = 16'($urandom_range(0, 6));
            loop_l = ($urandom_range(0, 1) == 1);
`ifdef LOOP_PLAYER_REVERSE_EN
            reverse = ($urandom_range(0, 1) == 1);
`endif
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 999) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

endmodule

`default_nettype wire
